// File: rtl/dynode_event_ctrl.sv
// dynode_event_ctrl: event sequencer for one dynode channel.
// Watches the baseline-corrected ADC stream and drives the baseline
// hold inputs (dyn_indet/dyn_event/dyn_pileup/dyn_pudump), the energy
// integrator gate (int_gate), the end-of-window strobe (evt_done),
// the last event width (evt_width) and the clean event count
// (evt_count). All outputs are registered.
// Ports: clk, reset (async, active low), enable, dyn_blcor, thr_low,
//        thr_high in; dyn_indet, dyn_event, dyn_pileup, dyn_pudump,
//        int_gate, evt_done, evt_width[7:0], evt_count[15:0] out.
// Build option: DYN_PILEUP_EXTEND_EN reloads the window once on the
// first pileup crossing, extending the integration gate.
module dynode_event_ctrl #(
    parameter int INT_LEN   = 32,
    parameter int MAX_WIDTH = 24,
    parameter int ARM_TMO   = 8,
    parameter int REARM_LEN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [11:0] dyn_blcor,
    input  logic [11:0] thr_low,
    input  logic [11:0] thr_high,
    output logic        dyn_indet,
    output logic        dyn_event,
    output logic        dyn_pileup,
    output logic        dyn_pudump,
    output logic        int_gate,
    output logic        evt_done,
    output logic [7:0]  evt_width,
    output logic [15:0] evt_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_EVENT,
        S_INTEG,
        S_PUDUMP,
        S_REARM
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  win_q, win_d;
    logic [7:0]  width_q, width_d;
    logic        pileup_q, pileup_d;
    logic        indet_q, indet_d;
    logic        event_q, event_d;
    logic        pudump_q, pudump_d;
    logic        gate_q, gate_d;
    logic        done_q, done_d;
    logic [7:0]  evt_width_q, evt_width_d;
    logic [15:0] evt_count_q, evt_count_d;
`ifdef DYN_PILEUP_EXTEND_EN
    logic        ext_q, ext_d;
`endif

    logic        above_low;
    logic        above_high;
    logic [7:0]  width_inc;
    logic [7:0]  win_inc;
    logic [7:0]  width_ev;
    logic        pile_now;

    assign above_low  = dyn_blcor > thr_low;
    assign above_high = dyn_blcor > thr_high;
    // width saturates at 255
    assign width_inc  = (width_q == 8'hFF) ? width_q : width_q + 8'd1;
    assign win_inc    = win_q + 8'd1;
    // width including the current EVENT sample
    assign width_ev   = above_low ? width_inc : width_q;
    // pileup including a crossing in this very sample
    assign pile_now   = pileup_q | above_high;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        win_d       = win_q;
        width_d     = width_q;
        pileup_d    = pileup_q;
        done_d      = 1'b0;
        evt_width_d = evt_width_q;
        evt_count_d = evt_count_q;
`ifdef DYN_PILEUP_EXTEND_EN
        ext_d       = ext_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                pileup_d = 1'b0;
`ifdef DYN_PILEUP_EXTEND_EN
                ext_d    = 1'b0;
`endif
                if (enable && above_low) begin
                    width_d = 8'd1;
                    cnt_d   = 8'd0;
                    if (above_high) begin
                        state_d = S_EVENT;
                        win_d   = 8'd1;
                    end else begin
                        state_d = S_ARM;
                    end
                end
            end
            S_ARM: begin
                if (above_high) begin
                    state_d = S_EVENT;
                    win_d   = 8'd1;
                    width_d = width_inc;
                end else if (!above_low) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 8'(ARM_TMO - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    width_d = width_inc;
                end
            end
            S_EVENT: begin
                width_d = width_ev;
                // over-wide pulse wins over window expiry
                if (above_low && width_inc == 8'(MAX_WIDTH)) begin
                    state_d = S_PUDUMP;
                    cnt_d   = 8'd0;
                end else if (win_q == 8'(INT_LEN)) begin
                    // truncated event: window ends while still above
                    state_d     = S_REARM;
                    cnt_d       = 8'd0;
                    done_d      = 1'b1;
                    evt_width_d = width_ev;
                    if (!pileup_q)
                        evt_count_d = evt_count_q + 16'd1;
                end else begin
                    win_d = win_inc;
                    if (!above_low)
                        state_d = S_INTEG;
                end
            end
            S_INTEG: begin
                if (above_high)
                    pileup_d = 1'b1;
`ifdef DYN_PILEUP_EXTEND_EN
                if (above_high && !ext_q) begin
                    ext_d = 1'b1;
                    win_d = 8'd1;
                end else
`endif
                if (win_q == 8'(INT_LEN)) begin
                    state_d     = S_REARM;
                    cnt_d       = 8'd0;
                    done_d      = 1'b1;
                    evt_width_d = width_q;
                    if (!pile_now)
                        evt_count_d = evt_count_q + 16'd1;
                end else begin
                    win_d = win_inc;
                end
            end
            S_PUDUMP: begin
                if (above_low) begin
                    cnt_d = 8'd0;
                end else if (cnt_q == 8'(REARM_LEN - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_REARM: begin
                if (cnt_q == 8'(REARM_LEN - 1)) begin
                    state_d  = S_IDLE;
                    pileup_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // outputs follow the next state so they settle with it
    always_comb begin
        indet_d  = state_d == S_ARM;
        event_d  = (state_d == S_EVENT) || (state_d == S_INTEG);
        gate_d   = event_d;
        pudump_d = state_d == S_PUDUMP;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            win_q       <= 8'd0;
            width_q     <= 8'd0;
            pileup_q    <= 1'b0;
            indet_q     <= 1'b0;
            event_q     <= 1'b0;
            pudump_q    <= 1'b0;
            gate_q      <= 1'b0;
            done_q      <= 1'b0;
            evt_width_q <= 8'd0;
            evt_count_q <= 16'd0;
`ifdef DYN_PILEUP_EXTEND_EN
            ext_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            width_q     <= width_d;
            pileup_q    <= pileup_d;
            indet_q     <= indet_d;
            event_q     <= event_d;
            pudump_q    <= pudump_d;
            gate_q      <= gate_d;
            done_q      <= done_d;
            evt_width_q <= evt_width_d;
            evt_count_q <= evt_count_d;
`ifdef DYN_PILEUP_EXTEND_EN
            ext_q       <= ext_d;
`endif
        end
    end

    assign dyn_indet  = indet_q;
    assign dyn_event  = event_q;
    assign dyn_pileup = pileup_q;
    assign dyn_pudump = pudump_q;
    assign int_gate   = gate_q;
    assign evt_done   = done_q;
    assign evt_width  = evt_width_q;
    assign evt_count  = evt_count_q;

endmodule

// File: doc/dynode_event_ctrl.md
Name: dynode_event_ctrl

Overview:
Event sequencer for one dynode channel. It watches the baseline-corrected ADC stream from the dynode baseline block and drives that block's hold inputs (dyn_indet, dyn_event, dyn_pileup, dyn_pudump). It also generates the integration gate and event-done strobe for the downstream energy integrator, and counts clean events for readout.

Parameters:
INT_LEN, 32, integration window length in clk cycles, counted from entry to EVENT (range 4..255)
MAX_WIDTH, 24, cycles above thr_low in EVENT before the event is dumped (range 2..255)
ARM_TMO, 8, maximum cycles in ARM without a thr_high crossing
REARM_LEN, 4, quiet cycles required before returning to IDLE

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset)
enable  input  1  allows IDLE->ARM; sampled only in IDLE
dyn_blcor  input  12  baseline-corrected ADC, 8.4 unsigned
thr_low  input  12  discriminator low threshold, 8.4 unsigned
thr_high  input  12  event confirm threshold, 8.4 unsigned
dyn_indet  output  1  high in ARM
dyn_event  output  1  high in EVENT and INTEG
dyn_pileup  output  1  sticky pileup flag for the current event
dyn_pudump  output  1  high in PUDUMP
int_gate  output  1  integration window for the energy integrator
evt_done  output  1  one-cycle strobe at end of window
evt_width  output  8  time-over-thr_low of last event, saturating at 255
evt_count  output  16  count of clean (non-pileup) events, wraps

Behaviour:
- Comparisons: "above" = dyn_blcor > thr (unsigned, strict); "below" = dyn_blcor <= thr_low.
- All outputs are registered. Latency is 1 clk from a dyn_blcor sample to its state and output effect.
- Reset (async, reset=0): state=IDLE; all outputs 0; all counters 0. Reset mid-event aborts immediately with no evt_done.
- States: IDLE, ARM, EVENT, INTEG, PUDUMP, REARM (one-hot or binary; implementer's choice).
- IDLE:
  - enable & above thr_low -> ARM.
  - If above thr_high in the same sample, go directly to EVENT.
- ARM (dyn_indet=1, arm counter increments):
  - above thr_high -> EVENT.
  - else below -> IDLE.
  - else arm counter == ARM_TMO-1 -> IDLE.
  - thr_high takes priority when multiple conditions hold.
- EVENT (dyn_event=1, int_gate=1):
  - win counter reset to 1 on entry; width counter increments while above thr_low.
  - below -> INTEG.
  - width == MAX_WIDTH -> PUDUMP; this takes priority over the win counter expiring.
- INTEG (dyn_event=1, int_gate=1):
  - win counter increments each cycle.
  - A sample above thr_high sets dyn_pileup, which holds until REARM exit.
  - win == INT_LEN -> REARM with evt_done=1 for that one cycle.
  - evt_width is latched at evt_done.
  - evt_count increments at evt_done only if dyn_pileup=0; 16'hFFFF wraps to 0.
- PUDUMP (dyn_pudump=1, int_gate=0, no evt_done):
  - Exit to IDLE after REARM_LEN consecutive below samples.
  - An above sample restarts the quiet count.
- REARM (outputs 0 except dyn_pileup):
  - REARM_LEN cycles, then IDLE; dyn_pileup clears on exit.
- Window reaching INT_LEN while still in EVENT: evt_done fires, then REARM (truncated event; evt_width = cycles counted so far).
- enable falling mid-event does not abort; it is only checked in IDLE.
- Threshold changes take effect on the next compare; software only changes thresholds while enable=0.

Optional Feature:
DYN_PILEUP_EXTEND_EN
- Defined: on the first pileup crossing in INTEG, the win counter is reloaded to 1, extending int_gate by up to INT_LEN cycles. This happens at most once per event; later crossings only keep dyn_pileup set.
- Undefined: the window is fixed at INT_LEN; a pileup only sets the flag.

Test Plan:
- Reset: reset=0 mid-INTEG with int_gate=1 -> all outputs 0 asynchronously; after release, state is IDLE and evt_count=0.
- Clean event (thr_low=0x080, thr_high=0x200, INT_LEN=32): blcor 0x100 for 1 cycle, 0x400 for 6, then 0x000 -> dyn_indet for 1 cycle; int_gate high for exactly 32 cycles; evt_done one cycle; evt_width=7; evt_count=1; dyn_pileup=0.
- Noise reject: blcor 0x100 for 3 cycles then 0x000 -> dyn_indet high 3 cycles, never dyn_event, no evt_done. blcor held at 0x100 for 20 cycles -> returns to IDLE after 8 cycles in ARM, re-arms per the IDLE rule.
- Pileup: clean pulse, then blcor 0x400 at window cycle 15 -> dyn_pileup=1 until REARM exit; evt_done fires; evt_count unchanged. With DYN_PILEUP_EXTEND_EN, int_gate total = 15+32 = 47 cycles.
- Wide pulse: blcor 0x400 held 30 cycles -> PUDUMP after 24 cycles above thr_low; int_gate drops; no evt_done; IDLE only after 4 quiet samples.
- Counter wrap: preload (force) evt_count=16'hFFFF, then one clean event -> 16'h0000.
